prio_write_regbank: RTL and testbench

- Bank of CHANNELS registers, each WIDTH bits, updated on one clock.
- Each channel has a per-channel default-clear and PORTS write ports; writes and clears resolve in fixed priority order: clear first, then port 0 upward, last matching write wins.
- Generalises the single-register "default assignment, then conditional override" pattern to multiple channels and writers.
- Adds per-channel written flags and a saturating conflict counter.
- Used as a control/status register block between multiple producers.

---
 rtl/prio_write_regbank.sv | 98 +++++++++
 tb/tb_prio_write_regbank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_write_regbank.sv
// Register bank with per-channel clear and prioritised multi-port writes (last matching port wins).
// Optional registered even parity per channel when PRIO_WRITE_REGBANK_PARITY_EN is defined.
module prio_write_regbank #(
    parameter int unsigned       WIDTH    = 8,
    parameter int unsigned       CHANNELS = 4,
    parameter int unsigned       PORTS    = 2,
    parameter logic [WIDTH-1:0]  CLR_VAL  = '0,
    parameter int unsigned       SELW     = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          clr_en,
    input  logic [PORTS-1:0]             wr_en,
    input  logic [PORTS*SELW-1:0]        wr_sel,
    input  logic [PORTS*WIDTH-1:0]       wr_data,
    output logic [CHANNELS*WIDTH-1:0]    dout,
    output logic [CHANNELS-1:0]          written,
    output logic [15:0]                  conflict_cnt,
    output logic                         bad_sel
`ifdef PRIO_WRITE_REGBANK_PARITY_EN
    ,output logic [CHANNELS-1:0]         parity
`endif
);

    logic [CHANNELS*WIDTH-1:0] nxt_dout;
    logic [CHANNELS-1:0]       nxt_written;
    logic                      conflict;
    logic                      bad;
    logic                      hit;
    logic [SELW-1:0]           sel;

    // Clear first, then ports ascending so the highest matching port lands last.
    always_comb begin
        nxt_dout    = dout;
        nxt_written = written;
        conflict    = 1'b0;
        bad         = 1'b0;
        hit         = 1'b0;
        sel         = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            hit = 1'b0;
            if (clr_en[c]) begin
                nxt_dout[c*WIDTH +: WIDTH] = CLR_VAL;
                nxt_written[c]             = 1'b0;
            end
            for (int unsigned p = 0; p < PORTS; p++) begin
                sel = wr_sel[p*SELW +: SELW];
                if (wr_en[p] && (32'(sel) == c)) begin
                    if (hit) begin
                        conflict = 1'b1;
                    end
                    hit                        = 1'b1;
                    nxt_dout[c*WIDTH +: WIDTH] = wr_data[p*WIDTH +: WIDTH];
                end
            end
            if (hit) begin
                nxt_written[c] = 1'b1;
            end
        end
        for (int unsigned p = 0; p < PORTS; p++) begin
            sel = wr_sel[p*SELW +: SELW];
            if (wr_en[p] && (32'(sel) >= CHANNELS)) begin
                bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout         <= {CHANNELS{CLR_VAL}};
            written      <= '0;
            conflict_cnt <= '0;
            bad_sel      <= 1'b0;
        end else begin
            dout    <= nxt_dout;
            written <= nxt_written;
            if (conflict && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (bad) begin
                bad_sel <= 1'b1;
            end
        end
    end

`ifdef PRIO_WRITE_REGBANK_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity <= {CHANNELS{^CLR_VAL}};
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                parity[c] <= ^nxt_dout[c*WIDTH +: WIDTH];
            end
        end
    end
`endif

endmodule

// File: tb/tb_prio_write_regbank.sv
// Randomised + directed bench: two banks (4 and 3 channels) checked every cycle against a behavioural model.
module tb_prio_write_regbank;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  clr_en = '0;
    logic [1:0]  wr_en = '0;
    logic [3:0]  wr_sel = '0;
    logic [15:0] wr_data = '0;

    logic [31:0] dout4;
    logic [3:0]  written4;
    logic [15:0] cnt4;
    logic        bad4;
    logic [23:0] dout3;
    logic [2:0]  written3;
    logic [15:0] cnt3;
    logic        bad3;
`ifdef PRIO_WRITE_REGBANK_PARITY_EN
    logic [3:0]  parity4;
    logic [2:0]  parity3;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    prio_write_regbank #(.WIDTH(8), .CHANNELS(4), .PORTS(2), .CLR_VAL(8'h00), .SELW(2)) dut (
        .clock(clock), .reset(reset), .clr_en(clr_en), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .dout(dout4), .written(written4), .conflict_cnt(cnt4), .bad_sel(bad4)
`ifdef PRIO_WRITE_REGBANK_PARITY_EN
        , .parity(parity4)
`endif
    );

    prio_write_regbank #(.WIDTH(8), .CHANNELS(3), .PORTS(2), .CLR_VAL(8'h00), .SELW(2)) dut3 (
        .clock(clock), .reset(reset), .clr_en(clr_en[2:0]), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .dout(dout3), .written(written3), .conflict_cnt(cnt3), .bad_sel(bad3)
`ifdef PRIO_WRITE_REGBANK_PARITY_EN
        , .parity(parity3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: k=0 is the 4-channel bank, k=1 the 3-channel bank.
    logic [7:0]  mdout [2][4];
    logic        mwr   [2][4];
    logic [15:0] mcnt  [2];
    logic        mbad  [2];
    logic [7:0]  ndout [2][4];
    logic        nwr   [2][4];
    logic [15:0] ncnt  [2];
    logic        nbad  [2];

    always_comb begin
        int n, hits, last;
        logic conf;
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 4 : 3;
            conf = 1'b0;
            nbad[k] = mbad[k];
            for (int c = 0; c < 4; c++) begin
                ndout[k][c] = mdout[k][c];
                nwr[k][c]   = mwr[k][c];
                hits = 0;
                last = -1;
                for (int p = 0; p < 2; p++) begin
                    if (wr_en[p] && int'(wr_sel[p*2 +: 2]) == c && c < n) begin
                        hits++;
                        last = p;
                    end
                end
                if (last >= 0) begin
                    ndout[k][c] = wr_data[last*8 +: 8];
                    nwr[k][c]   = 1'b1;
                end else if (clr_en[c] && c < n) begin
                    ndout[k][c] = 8'h00;
                    nwr[k][c]   = 1'b0;
                end
                if (hits >= 2) conf = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && int'(wr_sel[p*2 +: 2]) >= n) nbad[k] = 1'b1;
            end
            ncnt[k] = (conf && mcnt[k] != 16'hFFFF) ? mcnt[k] + 16'd1 : mcnt[k];
        end
    end

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                mdout[k][c] <= reset ? 8'h00 : ndout[k][c];
                mwr[k][c]   <= reset ? 1'b0 : nwr[k][c];
            end
            mcnt[k] <= reset ? 16'h0000 : ncnt[k];
            mbad[k] <= reset ? 1'b0 : nbad[k];
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clock) begin
        logic [31:0] d3p;
        logic [3:0]  w3p;
        d3p = {8'h00, dout3};
        w3p = {1'b0, written3};
        for (int c = 0; c < 4; c++) begin
            check($sformatf("dout4[%0d]", c), 32'(dout4[c*8 +: 8]), 32'(mdout[0][c]));
            check($sformatf("written4[%0d]", c), 32'(written4[c]), 32'(mwr[0][c]));
`ifdef PRIO_WRITE_REGBANK_PARITY_EN
            check($sformatf("parity4[%0d]", c), 32'(parity4[c]), 32'(^mdout[0][c]));
`endif
            if (c < 3) begin
                check($sformatf("dout3[%0d]", c), 32'(d3p[c*8 +: 8]), 32'(mdout[1][c]));
                check($sformatf("written3[%0d]", c), 32'(w3p[c]), 32'(mwr[1][c]));
            end
        end
        check("cnt4", 32'(cnt4), 32'(mcnt[0]));
        check("cnt3", 32'(cnt3), 32'(mcnt[1]));
        check("bad4", 32'(bad4), 32'(mbad[0]));
        check("bad3", 32'(bad3), 32'(mbad[1]));
    end

    task automatic step(input logic [3:0] c, input logic [1:0] e, input logic [3:0] s, input logic [15:0] d);
        clr_en  = c;
        wr_en   = e;
        wr_sel  = s;
        wr_data = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    initial begin
        int guard;
        repeat (2) @(posedge clock);
        #1;
        check("reset_dout", dout4, 32'h0);
        check("reset_written", 32'(written4), 32'h0);
        check("reset_cnt", 32'(cnt4), 32'h0);
        check("reset_bad", 32'(bad4), 32'h0);
        reset = 1'b0;

        // write beats clear, then clear alone
        step(4'b0010, 2'b01, 4'b0001, 16'h00A5);
        check("wr_beats_clr_dout1", 32'(dout4[15:8]), 32'hA5);
        check("wr_beats_clr_written1", 32'(written4[1]), 32'h1);
        step(4'b0010, 2'b00, 4'b0000, 16'h0000);
        check("clr_dout1", 32'(dout4[15:8]), 32'h00);
        check("clr_written1", 32'(written4[1]), 32'h0);

        // both ports hit channel 2: port 1 wins, one conflict per cycle
        step(4'b0000, 2'b11, 4'b1010, 16'h2211);
        check("conflict_dout2", 32'(dout4[23:16]), 32'h22);
        check("conflict_cnt1", 32'(cnt4), 32'h1);
        repeat (3) step(4'b0000, 2'b11, 4'b1010, 16'h2211);
        check("conflict_cnt4", 32'(cnt4), 32'h4);

        // distinct channels; sel 3 is out of range for the 3-channel bank
        step(4'b0000, 2'b11, 4'b1100, 16'h4433);
        check("split_dout0", 32'(dout4[7:0]), 32'h33);
        check("split_dout3", 32'(dout4[31:24]), 32'h44);
        check("split_cnt", 32'(cnt4), 32'h4);
        check("bad3_set", 32'(bad3), 32'h1);
        check("bad4_clear", 32'(bad4), 32'h0);
        check("bad3_dout0", 32'(dout3[7:0]), 32'h33);
        step(4'b0000, 2'b01, 4'b0001, 16'h0055);
        check("bad3_sticky", 32'(bad3), 32'h1);

`ifdef PRIO_WRITE_REGBANK_PARITY_EN
        step(4'b0000, 2'b01, 4'b0000, 16'h0007);
        check("parity_07", 32'(parity4[0]), 32'h1);
        step(4'b0000, 2'b01, 4'b0000, 16'h0003);
        check("parity_03", 32'(parity4[0]), 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
        end

        // asynchronous reset mid-cycle
        step(4'b0000, 2'b11, 4'b0111, 16'h6677);
        #3 reset = 1'b1;
        #1;
        check("async_dout", dout4, 32'h0);
        check("async_written", 32'(written4), 32'h0);
        check("async_cnt", 32'(cnt4), 32'h0);
        check("async_bad3", 32'(bad3), 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // drive the counter to its ceiling
        guard = 0;
        while (mcnt[0] != 16'hFFFE && guard < 70000) begin
            step(4'b0000, 2'b11, 4'b0101, 16'($urandom));
            guard++;
        end
        check("sat_reach", 32'(cnt4), 32'hFFFE);
        repeat (3) step(4'b0000, 2'b11, 4'b0101, 16'h1234);
        check("sat_cnt4", 32'(cnt4), 32'hFFFF);
        check("sat_cnt3", 32'(cnt3), 32'hFFFF);

        step(4'b0000, 2'b00, 4'b0000, 16'h0000);
        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
